// File: rtl/vec_exec_unit.sv
// vec_exec_unit: execute stage behind the ALU control decoder.
// Scalar ops, vector broadcast and vector+vector add finish in one cycle.
// Vector-by-scalar multiply runs one lane per cycle. Vector-by-scalar
// divide uses a restoring divider that makes one quotient bit per cycle.
// Optional build macro VEC_EXEC_SAT_EN: ADD/MUL/sum saturate high and
// SUB saturates at zero instead of wrapping.
module vec_exec_unit #(
   parameter int unsigned LANES = 4,
   parameter int unsigned W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           opALU,
   input  logic                 operALUe,
   input  logic                 operALUve,
   input  logic                 operSum,
   input  logic [W-1:0]         scalar_a,
   input  logic [W-1:0]         scalar_b,
   input  logic [LANES*W-1:0]   vec_a,
   input  logic [LANES*W-1:0]   vec_b,
   output logic                 ready,
   output logic                 done,
   output logic [W-1:0]         res_scalar,
   output logic [LANES*W-1:0]   res_vec,
   output logic                 div_zero
);

   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

   localparam logic [2:0] OP_MOV   = 3'b000;
   localparam logic [2:0] OP_BCAST = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_VMUL  = 3'b100;
   localparam logic [2:0] OP_VDIV  = 3'b110;
   localparam logic [2:0] OP_MUL   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      VMUL,
      VDIV,
      DONE
   } state_t;

   state_t               state_q;
   logic                 ready_q;
   logic                 done_q;
   logic [W-1:0]         res_scalar_q;
   logic [LANES*W-1:0]   res_vec_q;
   logic                 div_zero_q;
   logic [LANES*W-1:0]   va_q;
   logic [W-1:0]         b_q;
   logic [LANES*W-1:0]   wv_q;
   logic [LW-1:0]        lane_q;
   logic [BW-1:0]        bit_q;
   logic [W-1:0]         rem_q;
   logic [W-1:0]         quo_q;

   logic [W-1:0]         scalar_d;
   logic [LANES*W-1:0]   vs_d;
   logic [LANES*W-1:0]   sum_d;
   logic [W-1:0]         mul_lane_d;
   logic [W:0]           trial_d;
   logic                 ge_d;
   logic [W-1:0]         rem_d;
   logic [W-1:0]         quo_d;
   logic [W-1:0]         lane_res_d;
   logic [LANES*W-1:0]   wv_d;
   logic [LW-1:0]        lane_d;
   logic                 last_lane_d;
   logic                 last_bit_d;

   function automatic logic [W-1:0] f_add(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef VEC_EXEC_SAT_EN
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[W] ? '1 : s[W-1:0];
`else
      return x + y;
`endif
   endfunction

   function automatic logic [W-1:0] f_sub(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef VEC_EXEC_SAT_EN
      return (x < y) ? '0 : x - y;
`else
      return x - y;
`endif
   endfunction

   function automatic logic [W-1:0] f_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef VEC_EXEC_SAT_EN
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return (|p[2*W-1:W]) ? '1 : p[W-1:0];
`else
      return x * y;
`endif
   endfunction

   // Single-cycle results, per-lane multiply and one restoring-divide step
   always_comb begin
      scalar_d = '0;
      case (opALU)
         OP_MOV:  scalar_d = scalar_b;
         OP_ADD:  scalar_d = f_add(scalar_a, scalar_b);
         OP_SUB:  scalar_d = f_sub(scalar_a, scalar_b);
         OP_MUL:  scalar_d = f_mul(scalar_a, scalar_b);
         default: scalar_d = '0;
      endcase

      vs_d  = '0;
      sum_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (opALU == OP_BCAST) begin
            vs_d[i*W +: W] = scalar_b;
         end
         sum_d[i*W +: W] = f_add(vec_a[i*W +: W], vec_b[i*W +: W]);
      end

      mul_lane_d = f_mul(va_q[lane_q*W +: W], b_q);

      // Shift the next dividend bit into the partial remainder and try
      // subtracting the divisor; the quotient bit replaces the shifted-out bit
      trial_d = {rem_q, quo_q[W-1]};
      ge_d    = (trial_d >= {1'b0, b_q});
      rem_d   = ge_d ? W'(trial_d - {1'b0, b_q}) : trial_d[W-1:0];
      quo_d   = {quo_q[W-2:0], ge_d};

      lane_res_d = (state_q == VDIV) ? quo_d : mul_lane_d;
      wv_d       = wv_q;
      wv_d[lane_q*W +: W] = lane_res_d;

      lane_d      = lane_q + 1'b1;
      last_lane_d = (lane_q == LW'(LANES - 1));
      last_bit_d  = (bit_q == BW'(W - 1));
   end

   // Control FSM with registered handshake and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         done_q       <= 1'b0;
         res_scalar_q <= '0;
         res_vec_q    <= '0;
         div_zero_q   <= 1'b0;
         va_q         <= '0;
         b_q          <= '0;
         wv_q         <= '0;
         lane_q       <= '0;
         bit_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ready_q    <= 1'b0;
                  div_zero_q <= 1'b0;
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  if (operALUe) begin
                     res_scalar_q <= scalar_d;
                  end else if (operALUve) begin
                     if (opALU == OP_VMUL) begin
                        va_q    <= vec_a;
                        b_q     <= scalar_b;
                        lane_q  <= '0;
                        state_q <= VMUL;
                        done_q  <= 1'b0;
                     end else if (opALU == OP_VDIV) begin
                        if (scalar_b == '0) begin
                           res_vec_q  <= '1;
                           div_zero_q <= 1'b1;
                        end else begin
                           va_q    <= vec_a;
                           b_q     <= scalar_b;
                           quo_q   <= vec_a[W-1:0];
                           rem_q   <= '0;
                           lane_q  <= '0;
                           bit_q   <= '0;
                           state_q <= VDIV;
                           done_q  <= 1'b0;
                        end
                     end else begin
                        res_vec_q <= vs_d;
                     end
                  end else if (operSum) begin
                     res_vec_q <= sum_d;
                  end
               end
            end

            VMUL: begin
               wv_q <= wv_d;
               if (last_lane_d) begin
                  res_vec_q <= wv_d;
                  lane_q    <= '0;
                  state_q   <= DONE;
                  done_q    <= 1'b1;
               end else begin
                  lane_q <= lane_d;
               end
            end

            VDIV: begin
               if (last_bit_d) begin
                  // Lane finished: commit quotient, preload next lane's dividend
                  wv_q  <= wv_d;
                  quo_q <= va_q[lane_d*W +: W];
                  rem_q <= '0;
                  bit_q <= '0;
                  if (last_lane_d) begin
                     res_vec_q <= wv_d;
                     lane_q    <= '0;
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                  end else begin
                     lane_q <= lane_d;
                  end
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  bit_q <= bit_q + 1'b1;
               end
            end

            DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready      = ready_q;
   assign done       = done_q;
   assign res_scalar = res_scalar_q;
   assign res_vec    = res_vec_q;
   assign div_zero   = div_zero_q;

endmodule
